// File: rtl/mem_access_ctrl.sv
// Load/store unit bus sequencer: aligns, issues and retires one memory op at a time.
// Tracks the LL/SC reservation bit and reports AdEL/AdES/BUS faults.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter bit LLBIT_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    input  logic        llclr_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stallreq_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  exc_o,
    output logic [31:0] badvaddr_o
);

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
    localparam logic [3:0] OP_LL  = 4'd8;
    localparam logic [3:0] OP_SC  = 4'd9;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_ADEL = 2'd1;
    localparam logic [1:0] EXC_ADES = 2'd2;
    localparam logic [1:0] EXC_BUS  = 2'd3;

    localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ABORT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [3:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_badv;
    logic [1:0]  r_exc;
    logic [7:0]  r_cnt;
    logic        r_llbit;

    logic        w_in_valid;
    logic        w_in_store;
    logic        w_in_misal;
    logic        w_sc_early;
    logic        w_early;
    logic        w_accept;
    logic        w_tmo;
    logic        w_end;
    logic        w_fail;

    logic [3:0]  w_sel;
    logic [31:0] w_bwdata;
    logic        w_we;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ldata;

    // Classification of the op waiting at the stage input
    always_comb begin
        w_in_valid = 1'b1;
        w_in_store = 1'b0;
        w_in_misal = 1'b0;
        case (op_i)
            OP_LB, OP_LBU: begin
                w_in_misal = 1'b0;
            end
            OP_LH, OP_LHU: begin
                w_in_misal = addr_i[0];
            end
            OP_LW, OP_LL: begin
                w_in_misal = |addr_i[1:0];
            end
            OP_SB: begin
                w_in_store = 1'b1;
            end
            OP_SH: begin
                w_in_store = 1'b1;
                w_in_misal = addr_i[0];
            end
            OP_SW, OP_SC: begin
                w_in_store = 1'b1;
                w_in_misal = |addr_i[1:0];
            end
            default: begin
                w_in_valid = 1'b0;
            end
        endcase
    end

    assign w_sc_early = (op_i == OP_SC) & ~r_llbit;
    assign w_early    = ~w_in_valid | w_in_misal | w_sc_early;
    assign w_accept   = (r_state == S_IDLE) & req_valid_i & ~flush_i;

    // Counter holds (BUSY cycle index - 1), so the last allowed cycle ends it
    assign w_tmo  = (r_cnt == LP_TMO_LAST);
    assign w_end  = bus_ack_i | bus_err_i | w_tmo;
    assign w_fail = bus_err_i | (w_tmo & ~bus_ack_i);

    // Lane selection and store replication from the latched op
    always_comb begin
        w_sel    = 4'b1111;
        w_bwdata = r_wdata;
        w_we     = 1'b0;
        case (r_op)
            OP_LB, OP_LBU: begin
                w_sel = 4'b0001 << r_addr[1:0];
            end
            OP_LH, OP_LHU: begin
                w_sel = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            OP_SB: begin
                w_we     = 1'b1;
                w_sel    = 4'b0001 << r_addr[1:0];
                w_bwdata = {4{r_wdata[7:0]}};
            end
            OP_SH: begin
                w_we     = 1'b1;
                w_sel    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_bwdata = {2{r_wdata[15:0]}};
            end
            OP_SW, OP_SC: begin
                w_we = 1'b1;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_byte = bus_rdata_i[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = bus_rdata_i[7:0];
            2'd1: w_byte = bus_rdata_i[15:8];
            2'd2: w_byte = bus_rdata_i[23:16];
            2'd3: w_byte = bus_rdata_i[31:24];
            default: w_byte = bus_rdata_i[7:0];
        endcase
    end

    assign w_half = r_addr[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

    always_comb begin
        w_ldata = 32'd0;
        case (r_op)
            OP_LB:        w_ldata = {{24{w_byte[7]}}, w_byte};
            OP_LBU:       w_ldata = {24'd0, w_byte};
            OP_LH:        w_ldata = {{16{w_half[15]}}, w_half};
            OP_LHU:       w_ldata = {16'd0, w_half};
            OP_LW, OP_LL: w_ldata = bus_rdata_i;
            OP_SC:        w_ldata = 32'd1;
            default:      w_ldata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A flush that lands on the bus cycle's last beat needs no ABORT wait
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_early ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                unique case (1'b1)
                    flush_i & w_end:  w_next = S_IDLE;
                    flush_i & ~w_end: w_next = S_ABORT;
                    ~flush_i & w_end: w_next = S_DONE;
                    default:          w_next = S_BUSY;
                endcase
            end
            S_ABORT: begin
                if (w_end) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = 32'd0;
        bus_sel_o   = 4'd0;
        bus_wdata_o = 32'd0;
        stallreq_o  = 1'b0;
        done_o      = 1'b0;
        rdata_o     = 32'd0;
        exc_o       = EXC_NONE;
        badvaddr_o  = 32'd0;
        case (r_state)
            S_IDLE: begin
                stallreq_o = req_valid_i & ~flush_i;
            end
            S_BUSY, S_ABORT: begin
                bus_req_o   = 1'b1;
                bus_we_o    = w_we;
                bus_addr_o  = {r_addr[31:2], 2'b00};
                bus_sel_o   = w_sel;
                bus_wdata_o = w_bwdata;
                stallreq_o  = 1'b1;
            end
            S_DONE: begin
                done_o     = 1'b1;
                rdata_o    = r_rdata;
                exc_o      = r_exc;
                badvaddr_o = r_badv;
            end
            default: begin
                stallreq_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op    <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_badv  <= 32'd0;
            r_exc   <= EXC_NONE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= op_i;
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_cnt   <= 8'd0;
                        r_rdata <= 32'd0;
                        if (w_in_misal) begin
                            r_exc  <= w_in_store ? EXC_ADES : EXC_ADEL;
                            r_badv <= addr_i;
                        end else begin
                            r_exc  <= EXC_NONE;
                            r_badv <= 32'd0;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (!flush_i) begin
                        if (w_fail) begin
                            r_exc  <= EXC_BUS;
                            r_badv <= r_addr;
                        end else if (bus_ack_i) begin
                            r_rdata <= w_ldata;
                        end
                    end
                end
                S_ABORT: begin
                    r_cnt <= r_cnt + 8'd1;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Reservation updates retire with done_o; a flush in DONE discards them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_llbit <= 1'b0;
        end else if (!LLBIT_EN || llclr_i) begin
            r_llbit <= 1'b0;
        end else if (r_state == S_DONE && !flush_i && r_exc == EXC_NONE) begin
            if (r_op == OP_LL) begin
                r_llbit <= 1'b1;
            end else if (r_op == OP_SC && r_rdata[0]) begin
                r_llbit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized and directed bench for mem_access_ctrl against a
// behavioural model of alignment, lanes, latency and the LL/SC reservation.
module tb_mem_access_ctrl;

    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic [3:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        llclr_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic        bus_err_i;
    logic [31:0] bus_rdata_i;
    logic        stallreq_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic [1:0]  exc_o;
    logic [31:0] badvaddr_o;

    int n_checks;
    int n_errs;
    bit m_ll;

    mem_access_ctrl #(
        .TIMEOUT_CYC(TMO),
        .LLBIT_EN(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_i(req_valid_i),
        .op_i(op_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .flush_i(flush_i),
        .llclr_i(llclr_i),
        .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i),
        .bus_err_i(bus_err_i),
        .bus_rdata_i(bus_rdata_i),
        .stallreq_o(stallreq_o),
        .done_o(done_o),
        .rdata_o(rdata_o),
        .exc_o(exc_o),
        .badvaddr_o(badvaddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete memory op; model predicts every visible result
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input int dly, input bit use_err,
                         input logic [31:0] brd, input bit fl_done,
                         input bit clr_done, input string tag);
        bit          vld, st, mis, bus, chk_rd, seen;
        int          sz, exp_lat;
        logic [1:0]  exp_exc;
        logic [3:0]  exp_sel;
        logic [31:0] exp_bwd, exp_rd, exp_ba;
        longint      lane, span;

        vld = (op <= 4'd9);
        st  = (op == 5) || (op == 6) || (op == 7) || (op == 9);
        sz  = (op == 0 || op == 1 || op == 5) ? 1 :
              (op == 2 || op == 3 || op == 6) ? 2 : 4;
        mis = vld && (addr % sz != 0);
        bus = vld && !mis && !(op == 9 && !m_ll);
        exp_ba  = addr - (addr % 4);
        exp_sel = (sz == 4) ? 4'hF : 4'((sz == 1 ? 1 : 3) << (addr % 4));
        exp_bwd = (sz == 1) ? (wd % 256) * 32'h01010101 :
                  (sz == 2) ? (wd % 65536) * 32'h00010001 : wd;
        span = longint'(1) << (8 * sz);
        lane = (longint'(brd) >> (8 * (addr % 4))) % span;
        if ((op == 0 || op == 2) && lane >= span / 2) lane = lane - span;
        exp_rd = 32'(lane);
        if (op == 9) exp_rd = bus ? 32'd1 : 32'd0;
        if (!vld) exp_rd = 32'd0;
        if (mis) exp_exc = st ? 2'd2 : 2'd1;
        else if (bus && (use_err || dly >= TMO)) exp_exc = 2'd3;
        else exp_exc = 2'd0;
        exp_lat = !bus ? 1 : (dly >= TMO ? TMO + 1 : dly + 2);
        chk_rd = (exp_exc == 0) && (!vld || !st || op == 9);

        @(negedge clk);
        req_valid_i = 1'b1;
        op_i = op;
        addr_i = addr;
        wdata_i = wd;
        #1;
        n_checks++;
        if (stallreq_o !== 1'b1) begin
            n_errs++;
            $display("FAIL %s stall_idle: got %b want 1", tag, stallreq_o);
        end
        seen = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            bus_ack_i = 1'b0;
            bus_err_i = 1'b0;
            if (done_o === 1'b1) begin
                seen = 1;
                req_valid_i = 1'b0;
                n_checks++;
                if (c != exp_lat) begin
                    n_errs++;
                    $display("FAIL %s latency: got %0d want %0d", tag, c, exp_lat);
                end
                n_checks++;
                if (exc_o !== exp_exc) begin
                    n_errs++;
                    $display("FAIL %s exc: got %0d want %0d", tag, exc_o, exp_exc);
                end
                if (exp_exc != 0) begin
                    n_checks++;
                    if (badvaddr_o !== addr) begin
                        n_errs++;
                        $display("FAIL %s badv: got %h want %h", tag, badvaddr_o, addr);
                    end
                end
                if (chk_rd) begin
                    n_checks++;
                    if (rdata_o !== exp_rd) begin
                        n_errs++;
                        $display("FAIL %s rdata: got %h want %h", tag, rdata_o, exp_rd);
                    end
                end
                n_checks++;
                if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0) begin
                    n_errs++;
                    $display("FAIL %s done_quiet: got stall %b req %b want 0 0",
                             tag, stallreq_o, bus_req_o);
                end
                flush_i = fl_done;
                llclr_i = clr_done;
            end else begin
                n_checks++;
                if (bus_req_o !== bus || stallreq_o !== 1'b1) begin
                    n_errs++;
                    $display("FAIL %s busy: got req %b stall %b want %b 1",
                             tag, bus_req_o, stallreq_o, bus);
                end
                if (bus) begin
                    n_checks++;
                    if (bus_addr_o !== exp_ba || bus_sel_o !== exp_sel ||
                        bus_we_o !== st || (st && bus_wdata_o !== exp_bwd)) begin
                        n_errs++;
                        $display("FAIL %s bus: got a %h s %b w %b d %h want a %h s %b w %b d %h",
                                 tag, bus_addr_o, bus_sel_o, bus_we_o, bus_wdata_o,
                                 exp_ba, exp_sel, st, exp_bwd);
                    end
                end
                if (c - 1 == dly) begin
                    bus_ack_i = 1'b1;
                    bus_err_i = use_err;
                    bus_rdata_i = brd;
                end
            end
        end
        if (!seen) begin
            n_checks++;
            n_errs++;
            req_valid_i = 1'b0;
            $display("FAIL %s no_done: got none want done within 40 cycles", tag);
        end
        @(negedge clk);
        flush_i = 1'b0;
        llclr_i = 1'b0;
        n_checks++;
        if (done_o !== 1'b0) begin
            n_errs++;
            $display("FAIL %s done_width: got %b want 0", tag, done_o);
        end
        if (!fl_done && exp_exc == 0) begin
            if (op == 8) m_ll = 1;
            else if (op == 9 && bus) m_ll = 0;
        end
        if (clr_done) m_ll = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid_i = 0; op_i = 0; addr_i = 0; wdata_i = 0;
        flush_i = 0; llclr_i = 0; bus_ack_i = 0; bus_err_i = 0; bus_rdata_i = 0;
        m_ll = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus_req_o, bus_we_o, bus_sel_o} !== 6'd0) begin
            n_errs++;
            $display("FAIL rst_busctl: got %b want 0", {bus_req_o, bus_we_o, bus_sel_o});
        end
        n_checks++;
        if ({bus_addr_o, bus_wdata_o} !== 64'd0) begin
            n_errs++;
            $display("FAIL rst_busdata: got %h want 0", {bus_addr_o, bus_wdata_o});
        end
        n_checks++;
        if ({stallreq_o, done_o, exc_o} !== 4'd0) begin
            n_errs++;
            $display("FAIL rst_ctl: got %b want 0", {stallreq_o, done_o, exc_o});
        end
        n_checks++;
        if ({rdata_o, badvaddr_o} !== 64'd0) begin
            n_errs++;
            $display("FAIL rst_data: got %h want 0", {rdata_o, badvaddr_o});
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stallreq_o !== 1'b0) begin
            n_errs++;
            $display("FAIL rst_idle_stall: got %b want 0", stallreq_o);
        end
    endtask

    task automatic test_directed();
        do_op(4'd0, 32'h103, 32'h0, 0, 0, 32'h80FF_FF00, 0, 0, "lb_103");
        do_op(4'd1, 32'h102, 32'h0, 1, 0, 32'h0080_0000, 0, 0, "lbu_102");
        do_op(4'd2, 32'h102, 32'h0, 0, 0, 32'h8001_7FFF, 0, 0, "lh_102");
        do_op(4'd3, 32'h100, 32'h0, 2, 0, 32'h1234_F00D, 0, 0, "lhu_100");
        do_op(4'd4, 32'h102, 32'h0, 0, 0, 32'h0, 0, 0, "lw_adel");
        do_op(4'd6, 32'h101, 32'hABCD, 0, 0, 32'h0, 0, 0, "sh_ades");
        do_op(4'd5, 32'h401, 32'h0000_00A5, 0, 0, 32'h0, 0, 0, "sb_401");
        do_op(4'd6, 32'h402, 32'h0000_BEEF, 1, 0, 32'h0, 0, 0, "sh_402");
        do_op(4'd11, 32'h3, 32'h0, 0, 0, 32'h0, 0, 0, "bad_op");
    endtask

    task automatic test_llsc();
        do_op(4'd8, 32'h200, 32'h0, 0, 0, 32'hCAFE_0001, 0, 0, "ll_200");
        do_op(4'd9, 32'h200, 32'h1234, 0, 0, 32'h0, 0, 0, "sc_ok");
        do_op(4'd9, 32'h200, 32'h1234, 0, 0, 32'h0, 0, 0, "sc_again");
        do_op(4'd8, 32'h204, 32'h0, 0, 0, 32'h1, 0, 0, "ll_keep");
        do_op(4'd8, 32'h208, 32'h0, 0, 1, 32'h1, 0, 0, "ll_err");
        do_op(4'd9, 32'h204, 32'h55, 1, 0, 32'h0, 0, 0, "sc_after_err");
        do_op(4'd8, 32'h210, 32'h0, 0, 0, 32'h1, 1, 0, "ll_flushed");
        do_op(4'd9, 32'h210, 32'h1, 0, 0, 32'h0, 0, 0, "sc_no_res");
        do_op(4'd8, 32'h214, 32'h0, 0, 0, 32'h1, 0, 1, "ll_clr_same");
        do_op(4'd9, 32'h214, 32'h1, 0, 0, 32'h0, 0, 0, "sc_clr_same");
        do_op(4'd8, 32'h218, 32'h0, 0, 0, 32'h1, 0, 0, "ll_then_clr");
        @(negedge clk);
        llclr_i = 1'b1;
        @(negedge clk);
        llclr_i = 1'b0;
        m_ll = 0;
        do_op(4'd9, 32'h218, 32'h1, 0, 0, 32'h0, 0, 0, "sc_idle_clr");
    endtask

    task automatic test_timeout();
        do_op(4'd7, 32'h300, 32'hDEAD_BEEF, 1000, 0, 32'h0, 0, 0, "sw_timeout");
    endtask

    task automatic test_flush_abort();
        bit saw_done;
        saw_done = 0;
        @(negedge clk);
        req_valid_i = 1'b1; op_i = 4'd4; addr_i = 32'h80; wdata_i = 0;
        @(negedge clk);
        n_checks++;
        if (bus_req_o !== 1'b1) begin
            n_errs++;
            $display("FAIL abort_busy: got %b want 1", bus_req_o);
        end
        flush_i = 1'b1;
        req_valid_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            flush_i = 1'b0;
            if (done_o === 1'b1) saw_done = 1;
            n_checks++;
            if (bus_req_o !== 1'b1 || stallreq_o !== 1'b1) begin
                n_errs++;
                $display("FAIL abort_hold%0d: got req %b stall %b want 1 1",
                         k, bus_req_o, stallreq_o);
            end
            if (k == 3) begin
                bus_ack_i = 1'b1;
                bus_rdata_i = 32'h1111_2222;
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus_ack_i = 1'b0;
            if (done_o === 1'b1) saw_done = 1;
        end
        n_checks++;
        if (saw_done || bus_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
            n_errs++;
            $display("FAIL abort_end: got done %b req %b stall %b want 0 0 0",
                     saw_done, bus_req_o, stallreq_o);
        end
        do_op(4'd4, 32'h84, 32'h0, 0, 0, 32'h0BAD_F00D, 0, 0, "lw_after_abort");
    endtask

    task automatic test_reset_busy();
        bit saw_done;
        saw_done = 0;
        do_op(4'd8, 32'h500, 32'h0, 0, 0, 32'h7, 0, 0, "ll_pre_rst");
        @(negedge clk);
        req_valid_i = 1'b1; op_i = 4'd4; addr_i = 32'h600;
        @(negedge clk);
        n_checks++;
        if (bus_req_o !== 1'b1) begin
            n_errs++;
            $display("FAIL rstb_busy: got %b want 1", bus_req_o);
        end
        req_valid_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus_req_o !== 1'b0 || done_o !== 1'b0 || stallreq_o !== 1'b0) begin
            n_errs++;
            $display("FAIL rstb_drop: got req %b done %b stall %b want 0 0 0",
                     bus_req_o, done_o, stallreq_o);
        end
        @(negedge clk);
        rst = 1'b1;
        m_ll = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done_o === 1'b1) saw_done = 1;
        end
        n_checks++;
        if (saw_done) begin
            n_errs++;
            $display("FAIL rstb_nodone: got done 1 want 0");
        end
        do_op(4'd9, 32'h500, 32'h9, 0, 0, 32'h0, 0, 0, "sc_after_rst");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [3:0]  op;
        int          r;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 15);
            op = (r < 12) ? 4'(r) : ((r < 14) ? 4'd8 : 4'd9);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_op(op, a, $urandom, $urandom_range(0, 4),
                  ($urandom_range(0, 7) == 0), $urandom,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  "rand");
        end
    endtask

    initial begin
        n_checks = 0;
        n_errs = 0;
        test_reset();
        test_directed();
        test_llsc();
        test_timeout();
        test_flush_abort();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
